// File: rtl/muldiv_sequencer.sv
// Iterative mul/div/mod unit: shift-add multiply or restoring divide over WIDTH cycles.
// Result valid WIDTH+3 edges after accept (2 on divide-by-zero); held in DONE until out_ready.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} stateT;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} opT;

  stateT              state, nextState;
  opT                 op;
  logic [WIDTH-1:0]   opA, opB, aMag, bMag, absA, absB;
  logic               signQ, signR;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   resultReg, fixVal;
  logic               fixNeg, divByZeroReg, outValidReg;
  logic               accept, dbzCase;
  logic [WIDTH:0]     mulSum, remShift, remTrial;
  logic               qBit;
  logic [WIDTH-1:0]   newRem;

  assign accept  = in_valid && (state == IDLE) && (isMul || isDiv || isMod);
  assign dbzCase = (op != OP_MUL) && (opB == '0);
  assign absA    = opA[WIDTH-1] ? -opA : opA;
  assign absB    = opB[WIDTH-1] ? -opB : opB;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : '0);

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step.
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign remTrial = remShift - {1'b0, bMag};
  assign qBit     = ~remTrial[WIDTH];
  assign newRem   = qBit ? remTrial[WIDTH-1:0] : remShift[WIDTH-1:0];

  always_comb begin
    fixVal = acc[WIDTH-1:0];
    fixNeg = signQ;
    if (op == OP_MOD) begin
      fixVal = acc[2*WIDTH-1:WIDTH];
      fixNeg = signR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = PREP;
      PREP:    nextState = dbzCase ? DONE : RUN;
      RUN:     if (cnt == LAST) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    if (outValidReg && out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op           <= OP_MUL;
      opA          <= '0;
      opB          <= '0;
      aMag         <= '0;
      bMag         <= '0;
      signQ        <= 1'b0;
      signR        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      resultReg    <= '0;
      divByZeroReg <= 1'b0;
      outValidReg  <= 1'b0;
    end else begin
      outValidReg <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          opA <= op_a;
          opB <= op_b;
          op  <= isMul ? OP_MUL : (isDiv ? OP_DIV : OP_MOD);
        end
        PREP: begin
          aMag  <= absA;
          bMag  <= absB;
          signQ <= opA[WIDTH-1] ^ opB[WIDTH-1];
          signR <= opA[WIDTH-1];
          cnt   <= '0;
          acc   <= {{WIDTH{1'b0}}, (op == OP_MUL) ? absB : absA};
          if (dbzCase) begin
            resultReg    <= (op == OP_DIV) ? '1 : opA;
            divByZeroReg <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op == OP_MUL) acc <= {mulSum, acc[WIDTH-1:1]};
          else              acc <= {newRem, acc[WIDTH-2:0], qBit};
        end
        FIX: begin
          resultReg    <= fixNeg ? -fixVal : fixVal;
          divByZeroReg <= 1'b0;
        end
        DONE: outValidReg <= !(outValidReg && out_ready);
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = outValidReg;
  assign result      = resultReg;
  assign div_by_zero = divByZeroReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed results, divide-by-zero, backpressure, reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        isMul = 1'b0, isDiv = 1'b0, isMod = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        div_by_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat, busyCnt, staleCnt;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .isMul(isMul), .isDiv(isDiv), .isMod(isMod), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic m, input logic d, input logic r,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; isMul = m; isDiv = d; isMod = r; op_a = a; op_b = b;
    tick();
    in_valid = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen, and busy samples on the way.
  task automatic waitValid(input int limit, output int cycles, output int busyN);
    cycles = 0;
    busyN  = 0;
    while (!out_valid && cycles < limit) begin
      if (busy) busyN++;
      tick();
      cycles++;
    end
  endtask

  task automatic doOp(input logic m, input logic d, input logic r,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expRes, input logic expDbz, input int expLat,
                      input string tag);
    int cyc, bz;
    issue(m, d, r, a, b, tag);
    waitValid(100, cyc, bz);
    check({tag, "_latency"}, cyc, expLat);
    check({tag, "_busy_cycles"}, bz, expLat);
    check({tag, "_result"}, result, expRes);
    check({tag, "_dbz"}, div_by_zero, expDbz);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // in_valid without any op flag is ignored
    in_valid = 1'b1; op_a = 32'd5; op_b = 32'd5;
    tick();
    in_valid = 1'b0;
    check("noflag_busy", busy, 0);
    check("noflag_in_ready", in_ready, 1);

    doOp(1, 0, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 35, "mul_7x-3");
    doOp(0, 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 35, "div_-7/2");

    // mod, with a mul already presented during the run: it waits for the handoff
    issue(0, 0, 1, 32'hFFFF_FFF9, 32'd2, "mod_-7%2");
    in_valid = 1'b1; isMul = 1'b1; op_a = 32'd5; op_b = 32'd6;
    tick();
    check("b2b_in_ready_busy", in_ready, 0);
    waitValid(100, lat, busyCnt);
    check("mod_-7%2_latency", lat, 34);
    check("mod_-7%2_result", result, 32'hFFFF_FFFF);
    check("mod_-7%2_dbz", div_by_zero, 0);
    tick();
    check("b2b_handoff_valid", out_valid, 0);
    check("b2b_handoff_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; isMul = 1'b0;
    waitValid(100, lat, busyCnt);
    check("b2b_mul_latency", lat, 35);
    check("b2b_mul_result", result, 32'd30);
    tick();

    doOp(0, 1, 0, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 2, "div_by_zero");
    doOp(0, 0, 1, 32'd100, 32'd0, 32'd100, 1, 2, "mod_by_zero");
    doOp(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 35, "div_minneg");
    doOp(0, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 35, "mod_minneg");
    doOp(0, 0, 1, 32'd17, 32'hFFFF_FFFB, 32'd2, 0, 35, "mod_17%-5");

    // backpressure, with operand ports scrambled after accept
    out_ready = 1'b0;
    issue(1, 0, 0, 32'h0001_0000, 32'h0001_0000, "mul_bp");
    op_a = 32'h1234_5678; op_b = 32'hDEAD_BEEF;
    waitValid(100, lat, busyCnt);
    check("mul_bp_latency", lat, 35);
    check("mul_bp_result", result, 0);
    for (int i = 0; i < 10; i++) begin
      op_a = $urandom; op_b = $urandom;
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", result, 0);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);

    // reset in the middle of a divide
    issue(0, 1, 0, 32'd1000, 32'd7, "div_rst");
    for (int i = 0; i < 11; i++) tick();
    check("div_rst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_result", result, 0);
    staleCnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) staleCnt++;
    end
    check("rst_no_stale_valid", staleCnt, 0);
    doOp(1, 0, 0, 32'd3, 32'd4, 32'd12, 0, 35, "mul_3x4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle execution unit and its controller for the mul, div and mod instructions, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per valid/ready handshake and runs a shift-add multiply or restoring divide over WIDTH iterations. It holds the result until the pipeline consumes it, and drives busy so hazard logic can stall issue.

Parameters:
WIDTH, 32, operand/result width in bits (iteration count = WIDTH)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  execute stage presents an operation
in_ready  output  1  sequencer can accept (high only in IDLE)
isMul  input  1  decoded multiply flag
isDiv  input  1  decoded divide flag
isMod  input  1  decoded modulo flag
op_a  input  WIDTH  signed operand A (multiplicand / dividend)
op_b  input  WIDTH  signed operand B (multiplier / divisor)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  low WIDTH bits of product, quotient, or remainder
div_by_zero  output  1  qualifies result when out_valid; op_b was 0 on div/mod
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, div_by_zero=0, busy=0, in_ready=1 (in first cycle after rst deasserts). rst wins over every other input, including mid-operation; any in-flight op is discarded with no out_valid.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: in_ready=1. Accept when in_valid & in_ready & (isMul|isDiv|isMod). Latch operands and op. Flag priority if several are set: isMul > isDiv > isMod. in_valid with no flag set: no state change, nothing latched.
- PREP (1 cycle): take magnitudes of op_a/op_b and record sign_q = a_sign^b_sign and sign_r = a_sign. For div/mod with op_b==0, go to DONE directly. Otherwise go to RUN with iteration counter=0.
- RUN (WIDTH cycles): one iteration per cycle, counter increments. Mul uses shift-add on the magnitudes into a 2*WIDTH accumulator. Div/mod uses restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder. Leave RUN when counter==WIDTH-1.
- FIX (1 cycle):
  - mul: result = low WIDTH bits of product, negated if sign_q.
  - div: quotient, negated if sign_q.
  - mod: remainder, negated if sign_r (remainder takes the dividend's sign).
  - Truncating (round-toward-zero) semantics.
  - Most-negative / -1: quotient = 0x80000000 (wrap), remainder = 0, no flag.
- Divide by zero: div result = all ones; mod result = op_a unchanged; div_by_zero=1.
- DONE: out_valid=1, result/div_by_zero stable. Return to IDLE on out_valid & out_ready. out_valid drops the following cycle. No new accept in the same cycle as result handoff.
- Latency: accept edge is E0. Normal op has out_valid high after edge E0+WIDTH+3 (35 for WIDTH=32). Divide-by-zero has out_valid high after E0+2.
- Backpressure: out_ready low holds DONE indefinitely, with result unchanged.
- Operands on ports are don't-care after acceptance. Changes to them must not affect result.
- busy = (state != IDLE). in_ready = (state == IDLE).

Test Plan:
- mul op_a=7, op_b=0xFFFFFFFD (-3), out_ready=1 -> out_valid exactly 35 edges after accept, result=0xFFFFFFEB, div_by_zero=0, busy high 35 cycles.
- div op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFD. mod with same operands -> result=0xFFFFFFFF. Back-to-back ops accepted only after each result handoff.
- div op_a=100, op_b=0 -> out_valid 2 edges after accept, result=0xFFFFFFFF, div_by_zero=1. mod op_a=100, op_b=0 -> result=100, div_by_zero=1.
- div op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000. mod with same operands -> result=0, div_by_zero=0.
- mul 0x10000 x 0x10000, out_ready held 0 for 10 cycles after out_valid -> out_valid and result=0 stay stable, in_ready=0 throughout; handoff on out_ready=1, IDLE next cycle. Operands toggled after accept do not change result.
- rst asserted for 1 cycle at RUN iteration 10 of a div -> next cycle IDLE, out_valid=0, busy=0, in_ready=1; no stale result ever appears. New mul 3x4 then returns 12.
